// File: rtl/ptp_tsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ptp_tsu_pkg
// Brief    : Shared types and field widths for the TSU timestamp queue.
// Revision : 1.0 - initial release
// ============================================================================
package ptp_tsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PARSE = 2'd1,
        GRACE = 2'd2
    } state_t;

    localparam int SEC_W   = 48;
    localparam int NS_W    = 32;
    localparam int INFOR_W = 32;
    localparam int ENTRY_W = SEC_W + NS_W + INFOR_W;

    // Queue entries are stored {sec, ns, infor}, msb first.
    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [SEC_W-1:0]   sec,
        input logic [NS_W-1:0]    ns,
        input logic [INFOR_W-1:0] infor
    );
        return {sec, ns, infor};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptp_ts_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ptp_ts_fifo
// Brief    : Synchronous first-word-fall-through FIFO holding timestamp
//            entries; head word is always presented on dout.
// Revision : 1.0 - initial release
// ============================================================================
module ptp_ts_fifo
    import ptp_tsu_pkg::*;
#(
    parameter int AW = 4,
    parameter int W  = ENTRY_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   cnt
);

    localparam int c_DEPTH = 2**AW;

    logic [W-1:0]  r_mem [c_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          w_pop;
    logic          w_push;

    // A pop only counts when something is held; a push into a full queue is
    // only accepted when the head leaves in the same cycle.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    assign full  = (r_cnt == (AW+1)'(c_DEPTH));
    assign empty = (r_cnt == '0);
    assign cnt   = r_cnt;
    assign dout  = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; clear overrides any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ptp_ts_queue.sv
`default_nettype none
// ============================================================================
// Module   : ptp_ts_queue
// Brief    : Latches RTC time at every frame SOP, waits for the parser's PTP
//            verdict and queues {sec, ns, infor} for the host to drain.
// Revision : 1.0 - initial release
// ============================================================================
module ptp_ts_queue
    import ptp_tsu_pkg::*;
#(
    parameter int AW        = 4,
    parameter int EOP_GRACE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                int_valid,
    input  logic                int_sop,
    input  logic                int_eop,
    input  logic                ptp_found,
    input  logic [INFOR_W-1:0]  ptp_infor,
    input  logic [SEC_W-1:0]    rtc_sec,
    input  logic [NS_W-1:0]     rtc_ns,
    input  logic                q_rd,
    input  logic                q_clear,
    output logic                q_valid,
    output logic [SEC_W-1:0]    q_sec,
    output logic [NS_W-1:0]     q_ns,
    output logic [INFOR_W-1:0]  q_infor,
    output logic [AW:0]         q_cnt,
    output logic                q_ovf
);

    localparam int c_GW = (EOP_GRACE > 1) ? $clog2(EOP_GRACE) : 1;

    state_t              r_state;
    logic [c_GW-1:0]     r_gcnt;
    logic [SEC_W-1:0]    r_ts_sec;
    logic [NS_W-1:0]     r_ts_ns;
    logic                r_ovf;
    logic                w_sop;
    logic                w_eop;
    logic                w_found_ok;
    logic                w_full;
    logic                w_empty;
    logic [ENTRY_W-1:0]  w_head;

    assign w_sop = int_valid && int_sop;
    assign w_eop = int_valid && int_eop;

    // During an SOP beat the parser still shows the previous frame's verdict,
    // so a verdict is only taken while waiting and outside SOP beats.
    assign w_found_ok = ptp_found && !w_sop &&
                        ((r_state == PARSE) || (r_state == GRACE));

    // Capture RTC time at every frame start, regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts_sec <= '0;
            r_ts_ns  <= '0;
        end else if (w_sop) begin
            r_ts_sec <= rtc_sec;
            r_ts_ns  <= rtc_ns;
        end
    end

    // Frame tracking: wait for the verdict, allowing a short window past EOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sop) r_state <= PARSE;
                end
                PARSE: begin
                    if (w_sop) begin
                        r_state <= PARSE;
                    end else if (ptp_found) begin
                        r_state <= IDLE;
                    end else if (w_eop) begin
                        r_state <= GRACE;
                        r_gcnt  <= '0;
                    end
                end
                GRACE: begin
                    if (w_sop) begin
                        r_state <= PARSE;
                    end else if (ptp_found) begin
                        r_state <= IDLE;
                    end else if (r_gcnt == c_GW'(EOP_GRACE - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky overflow: a push met a full queue with no pop to make room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (q_clear) begin
            r_ovf <= 1'b0;
        end else if (w_found_ok && w_full && !q_rd) begin
            r_ovf <= 1'b1;
        end
    end

    ptp_ts_fifo #(
        .AW (AW),
        .W  (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_found_ok),
        .pop   (q_rd),
        .clear (q_clear),
        .din   (pack_entry(r_ts_sec, r_ts_ns, ptp_infor)),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .cnt   (q_cnt)
    );

    assign q_valid                 = !w_empty;
    assign {q_sec, q_ns, q_infor}  = w_head;
    assign q_ovf                   = r_ovf;

endmodule
`default_nettype wire
